// File: rtl/basic_axis_example_tlast_gen.sv
// AXI4-Stream pass-through that frames beats into packets of pkt_len beats and tags tlast.
// Optional macro BASIC_AXIS_EXAMPLE_TLAST_GEN_PKT_CNT_EN adds a 32-bit completed-packet counter.
module basic_axis_example_tlast_gen #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_LEN_WIDTH-1:0]  pkt_len,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast
`ifdef BASIC_AXIS_EXAMPLE_TLAST_GEN_PKT_CNT_EN
  ,
  output logic [31:0]             pkt_count
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = C_LEN_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [C_LEN_WIDTH-1:0]  count_q, count_d;
  logic [C_LEN_WIDTH-1:0]  eff_len;
  logic                    beat_last;
  logic                    accept;

  logic                    ready_q, ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [C_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [C_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                    skid_last_q, skid_last_d;
  logic                    load_out;

  assign accept  = s_axis_tvalid & ready_q;
  assign eff_len = (pkt_len == '0) ? LEN_ONE : pkt_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The counter holds beats still owed to the open packet; pkt_len only matters in IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          count_d = eff_len - LEN_ONE;
          state_d = (eff_len == LEN_ONE) ? IDLE : ACTIVE;
        end
        ACTIVE: begin
          count_d = count_q - LEN_ONE;
          if (count_q == LEN_ONE) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    beat_last = 1'b0;
    case (state_q)
      IDLE:    beat_last = (eff_len == LEN_ONE);
      ACTIVE:  beat_last = (count_q == LEN_ONE);
      default: beat_last = 1'b0;
    endcase
  end

  // Output stage refills from the skid entry first so ordering is kept across stalls.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    load_out     = ~out_valid_q | m_axis_tready;
    if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = s_axis_tdata;
          out_last_d = beat_last;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_last_d  = beat_last;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;

`ifdef BASIC_AXIS_EXAMPLE_TLAST_GEN_PKT_CNT_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else if (out_valid_q & m_axis_tready & out_last_q) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
